gray_counter_param: RTL
=======================

Name: gray_counter_param

Overview:
- Parametrised, registered Gray-code up/down counter; the sequential successor to the team's fixed 4-bit binary-to-Gray converter.
- Keeps a binary count internally and presents registered Gray and binary views of the same value.
- Supports load, enable, direction, and a wrap or saturate mode.
- Used as the pointer/sequence source for clock-domain-crossing FIFOs and position encoders elsewhere in the design.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- WRAP, 1, 1 = wrap at the count limits; 0 = saturate at the count limits.
- RESET_VALUE, 0, binary value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- enable  input  1  advance the count one step this cycle.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  load load_value this cycle.
- load_value  input  WIDTH  binary value to load.
- binary_output  output  WIDTH  registered binary count.
- grey_output  output  WIDTH  registered Gray code of binary_output.
- terminal_count  output  1  combinational limit flag: count == all-ones when up_down=1, count == 0 when up_down=0.
- wrap_pulse  output  1  registered one-cycle pulse, asserted the cycle after a wrap.
- saturated  output  1  registered; high while a count request is held at a limit (WRAP=0 only).

Behaviour:
- Clocking: one clock domain; all state updates on the rising edge of clk.
- Reset: synchronous, active-low. Evaluated only at a clk edge with rst_n=0.
  - binary_output = RESET_VALUE.
  - grey_output = RESET_VALUE ^ (RESET_VALUE >> 1).
  - wrap_pulse = 0, saturated = 0.
  - Reset overrides load and enable, including mid-count.
- Priority per cycle: reset > load > enable > hold.
- Gray encoding:
  - grey_output[WIDTH-1] = bin[WIDTH-1].
  - grey_output[i] = bin[i+1] ^ bin[i] for i < WIDTH-1.
  - Computed from the next binary value and registered together with it. The two outputs always describe the same count in the same cycle; there is no one-cycle skew.
- Latency: load or step is visible on the outputs 1 cycle after the sampling edge.
- Load:
  - binary_output <= load_value; grey_output <= gray(load_value).
  - wrap_pulse <= 0, saturated <= 0.
  - enable is ignored in that cycle.
- Step (enable=1, load=0):
  - up_down=1: bin+1. At all-ones: WRAP=1 gives 0 with wrap_pulse <= 1; WRAP=0 holds all-ones with saturated <= 1.
  - up_down=0: bin-1. At 0: WRAP=1 gives all-ones with wrap_pulse <= 1; WRAP=0 holds 0 with saturated <= 1.
  - Otherwise wrap_pulse <= 0 and saturated <= 0.
- Hold (enable=0, load=0): count unchanged, wrap_pulse <= 0, saturated keeps its value.
- Arithmetic is modulo 2^WIDTH; there is no carry-out port.
- Single-bit-change invariant: every step that moves the count, including a wrap, changes exactly one bit of grey_output. Load and reset are exempt.
- A direction change takes effect on the same edge; no idle cycle is required.
- terminal_count follows up_down combinationally, with no register.

Test Plan:
- Reset then count up (WIDTH=4, WRAP=1): rst_n=0 for 2 cycles, then enable=1, up_down=1 for 16 cycles.
  - grey_output sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - wrap_pulse is high only in the cycle grey returns to 0000.
  - terminal_count is high while binary=1111.
- Count down through zero: from binary 0, enable=1, up_down=0.
  - Next cycle binary=1111, grey=1000, wrap_pulse=1.
  - Following step: binary=1110, grey=1001, wrap_pulse=0.
- Load priority: at binary=5, drive load=1, load_value=4'b0011, enable=1.
  - Next cycle binary=0011, grey=0010; no step is applied.
- Saturate mode (WRAP=0):
  - Load 1111, then up for 3 cycles: binary stays 1111, saturated=1, wrap_pulse=0.
  - Switch up_down=0: next binary=1110, saturated=0.
- Reset mid-operation (RESET_VALUE=4'b0101): while counting up at binary=9, pull rst_n=0 for 1 cycle.
  - Next cycle binary=0101, grey=0111, wrap_pulse=0, saturated=0.
- Randomised checker (WIDTH=8, WRAP=1): 2000 cycles of random enable/up_down, with occasional load.
  - On every non-load, non-reset count change, popcount(grey_prev ^ grey_now) == 1.
  - grey_output == binary_output ^ (binary_output >> 1) on every cycle.

Source files
------------

// File: rtl/gray_counter_param.sv
// Registered Gray-code up/down counter with load, enable and wrap/saturate limit handling.
// Binary and Gray views are registered together so they always describe the same count.
module gray_counter_param #(
    parameter int              WIDTH       = 4,
    parameter bit              WRAP        = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] binary_output,
    output logic [WIDTH-1:0] grey_output,
    output logic             terminal_count,
    output logic             wrap_pulse,
    output logic             saturated
);

    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] ALL_ZEROS  = '0;
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             at_max, at_min;

    assign at_max = (bin_q == ALL_ONES);
    assign at_min = (bin_q == ALL_ZEROS);

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (load) begin
            bin_d = load_value;
            sat_d = 1'b0;
        end else if (enable) begin
            sat_d = 1'b0;
            if (up_down) begin
                if (!at_max) begin
                    bin_d = bin_q + ONE;
                end else if (WRAP) begin
                    bin_d  = ALL_ZEROS;
                    wrap_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    bin_d = bin_q - ONE;
                end else if (WRAP) begin
                    bin_d  = ALL_ONES;
                    wrap_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end
        end
        // Gray is derived from the next binary value so both registers update on the same edge.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= RESET_VALUE;
            gray_q <= RESET_GRAY;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign binary_output  = bin_q;
    assign grey_output    = gray_q;
    assign wrap_pulse     = wrap_q;
    assign saturated      = sat_q;
    assign terminal_count = up_down ? at_max : at_min;

endmodule
